branch_compare_seq: RTL and testbench
=====================================

BRANCH_COMPARE_SEQ -- requirements
Module: branch_compare_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand width in bits.
REQ-002 SHALL have parameter CHUNK, default 8, bits compared per cycle; WIDTH % CHUNK == 0 and CHUNK >= 1 are required, so NCH = WIDTH/CHUNK.
REQ-003 SHALL have port i_clk  input  1  clock, rising edge; reset is asynchronous and active-low.
REQ-004 SHALL have port i_rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port i_valid  input  1  request valid.
REQ-006 SHALL have port o_ready  output  1  request accepted when i_valid && o_ready.
REQ-007 SHALL have port i_rd1  input  WIDTH  operand A.
REQ-008 SHALL have port i_rd2  input  WIDTH  operand B.
REQ-009 SHALL have port i_funct3  input  3  RV branch funct3: 000 BEQ, 001 BNE, 100 BLT, 101 BGE, 110 BLTU, 111 BGEU.
REQ-010 SHALL have port i_flush  input  1  synchronous abort.
REQ-011 SHALL have port o_valid  output  1  result valid.
REQ-012 SHALL have port i_ready  input  1  result consumed when o_valid && i_ready.
REQ-013 SHALL have ports o_br_equal, o_br_less, o_taken, o_illegal  output  1 each  registered result flags.

Function
REQ-014 SHALL implement FSM states IDLE, RUN, DONE; o_ready = 1 only in IDLE; o_valid = 1 only in DONE.
REQ-015 IDLE: on accept, SHALL capture i_rd1, i_rd2, i_funct3, set chunk index idx = NCH-1, go to RUN.
REQ-016 RUN: each cycle SHALL compare chunk idx (bits idx*CHUNK+CHUNK-1 .. idx*CHUNK) of A and B as unsigned values.
REQ-017 For signed modes (funct3[1] = 0), the MSB chunk (idx = NCH-1) SHALL be compared with its top bit inverted in both operands; all other chunks compare unsigned.
REQ-018 If the chunks differ, SHALL register equal = 0 and less = (chunkA < chunkB), then go to DONE (early termination).
REQ-019 If the chunks are equal and idx == 0, SHALL register equal = 1 and less = 0, then go to DONE; otherwise idx decrements and the FSM stays in RUN.
REQ-020 Latency: k RUN cycles, k = 1 + number of equal chunks above the first differing chunk (k = NCH if A == B); o_valid rises on the clock edge ending the deciding RUN cycle.
REQ-021 o_taken SHALL be: BEQ equal; BNE !equal; BLT/BLTU less; BGE/BGEU !less.
REQ-022 funct3 010 or 011 SHALL set o_illegal = 1 and o_taken = 0; the compare still runs, and o_br_equal and o_br_less remain valid.
REQ-023 DONE: all outputs SHALL hold stable until i_ready = 1, then go to IDLE; no new request is accepted in that same cycle.
REQ-024 i_valid SHALL be ignored while not in IDLE.
REQ-025 i_flush SHALL force IDLE on the next edge from any state, dropping o_valid, with priority over all handshakes; flush in IDLE does not block a later accept but cancels a same-cycle accept.
REQ-026 Result flags SHALL retain the last completed result while in IDLE or RUN; they are meaningful only when o_valid = 1.

Reset
REQ-027 On i_rst_n = 0 (asynchronous), SHALL set state = IDLE, o_valid = 0, o_br_equal = 0, o_br_less = 0, o_taken = 0, o_illegal = 0, idx = 0; o_ready = 1 while reset is held and after release.
REQ-028 Reset asserted mid-RUN or in DONE SHALL discard the operation, and no o_valid SHALL follow.

Verification (WIDTH = 32, CHUNK = 8)
REQ-029 BEQ, rd1 = rd2 = 0x00000005 -> 4 RUN cycles, then o_valid, equal = 1, less = 0, taken = 1.
REQ-030 BLT, rd1 = 0xFFFFFFFF, rd2 = 0x00000001 -> 1 RUN cycle, less = 1, taken = 1; same operands with BLTU -> less = 0, taken = 0.
REQ-031 BGEU, rd1 = 0x12345600, rd2 = 0x12345601 -> 4 RUN cycles, less = 1, equal = 0, taken = 0.
REQ-032 Hold i_ready = 0 for 3 cycles in DONE while pulsing i_valid -> outputs stable, o_ready = 0, request ignored; i_ready = 1 -> IDLE next cycle.
REQ-033 i_flush in the 2nd RUN cycle, and separately i_rst_n low in RUN -> IDLE, o_valid never asserted for that request; the next request completes normally.
REQ-034 funct3 = 010, rd1 = rd2 = 0 -> o_illegal = 1, o_taken = 0, o_br_equal = 1.

Source files
------------

// File: rtl/branch_compare_seq_if.sv
// Request/result bundle for the sequential branch comparator.
//
// Handshake: a request transfers on a rising clock edge where i_valid && o_ready
// are both high; a result transfers on an edge where o_valid && i_ready are both
// high. A side that raises valid keeps it and its payload steady until the
// transfer happens. i_flush is a synchronous abort and overrides both handshakes.
interface branch_compare_seq_if #(
   parameter int WIDTH = 32
);
   logic             i_valid;
   logic             o_ready;
   logic [WIDTH-1:0] i_rd1;
   logic [WIDTH-1:0] i_rd2;
   logic [2:0]       i_funct3;
   logic             i_flush;
   logic             o_valid;
   logic             i_ready;
   logic             o_br_equal;
   logic             o_br_less;
   logic             o_taken;
   logic             o_illegal;

   modport master (
      output i_valid, i_rd1, i_rd2, i_funct3, i_flush, i_ready,
      input  o_ready, o_valid, o_br_equal, o_br_less, o_taken, o_illegal
   );

   modport slave (
      input  i_valid, i_rd1, i_rd2, i_funct3, i_flush, i_ready,
      output o_ready, o_valid, o_br_equal, o_br_less, o_taken, o_illegal
   );
endinterface

// File: rtl/branch_compare_seq.sv
// Multi-cycle RISC-V branch comparator: walks the operands CHUNK bits per cycle
// from the most significant chunk down and stops at the first differing chunk.
// Signed modes flip the sign bit of the top chunk so an unsigned chunk compare
// gives the two's-complement ordering.
module branch_compare_seq #(
   parameter int WIDTH = 32,
   parameter int CHUNK = 8
) (
   input  logic                 i_clk,
   input  logic                 i_rst_n,
   branch_compare_seq_if.slave  cmp_if,
   output logic [1:0]           o_dbg_state
);
   localparam int NCH = WIDTH / CHUNK;
   localparam int IW  = (NCH > 1) ? $clog2(NCH) : 1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic [IW-1:0]      idx_q;
   logic [WIDTH-1:0]   a_q, b_q;
   logic [2:0]         f3_q;
   logic               eq_q, lt_q, taken_q, ill_q;

   logic [CHUNK-1:0]   chunk_a, chunk_b;
   logic               chunk_ne, chunk_lt, last_chunk, decide, accept;
   logic               eq_d, lt_d, taken_d, ill_d;

   // Select the current chunk, apply sign correction, and derive the result flags.
   always_comb begin
      chunk_a = a_q[int'(idx_q)*CHUNK +: CHUNK];
      chunk_b = b_q[int'(idx_q)*CHUNK +: CHUNK];
      if (!f3_q[1] && (idx_q == IW'(NCH-1))) begin
         chunk_a[CHUNK-1] = ~chunk_a[CHUNK-1];
         chunk_b[CHUNK-1] = ~chunk_b[CHUNK-1];
      end
      chunk_ne   = (chunk_a != chunk_b);
      chunk_lt   = (chunk_a < chunk_b);
      last_chunk = (idx_q == '0);
      accept     = (state_q == S_IDLE) && cmp_if.i_valid && !cmp_if.i_flush;
      decide     = (state_q == S_RUN) && !cmp_if.i_flush && (chunk_ne || last_chunk);
      eq_d       = !chunk_ne;
      lt_d       = chunk_ne && chunk_lt;
      ill_d      = (f3_q[2:1] == 2'b01);
      case (f3_q)
         3'b000:         taken_d = eq_d;
         3'b001:         taken_d = !eq_d;
         3'b100, 3'b110: taken_d = lt_d;
         3'b101, 3'b111: taken_d = !lt_d;
         default:        taken_d = 1'b0;
      endcase
   end

   // State register.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) state_q <= S_IDLE;
      else          state_q <= state_d;
   end

   // Next-state logic; flush beats every handshake.
   always_comb begin
      state_d = state_q;
      if (cmp_if.i_flush) begin
         state_d = S_IDLE;
      end else begin
         case (state_q)
            S_IDLE:  if (cmp_if.i_valid) state_d = S_RUN;
            S_RUN:   if (chunk_ne || last_chunk) state_d = S_DONE;
            S_DONE:  if (cmp_if.i_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
         endcase
      end
   end

   // Operand capture, chunk index walk, and result flag registers.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         idx_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         f3_q    <= '0;
         eq_q    <= 1'b0;
         lt_q    <= 1'b0;
         taken_q <= 1'b0;
         ill_q   <= 1'b0;
      end else if (accept) begin
         a_q   <= cmp_if.i_rd1;
         b_q   <= cmp_if.i_rd2;
         f3_q  <= cmp_if.i_funct3;
         idx_q <= IW'(NCH-1);
      end else if (decide) begin
         eq_q    <= eq_d;
         lt_q    <= lt_d;
         taken_q <= taken_d;
         ill_q   <= ill_d;
      end else if ((state_q == S_RUN) && !cmp_if.i_flush) begin
         idx_q <= idx_q - IW'(1);
      end
   end

   // Outputs are decoded from state and the result registers only.
   always_comb begin
      cmp_if.o_ready      = (state_q == S_IDLE);
      cmp_if.o_valid      = (state_q == S_DONE);
      cmp_if.o_br_equal   = eq_q;
      cmp_if.o_br_less    = lt_q;
      cmp_if.o_taken      = taken_q;
      cmp_if.o_illegal    = ill_q;
      o_dbg_state         = state_q;
   end
endmodule

// File: tb/tb_branch_compare_seq.sv
// Bench for branch_compare_seq with WIDTH=32, CHUNK=8.
module tb_branch_compare_seq;
   localparam int W = 32;
   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   // ---------------- clock / reset ----------------
   logic       clk   = 1'b0;
   logic       rst_n = 1'b0;
   logic [1:0] dbg_state;
   always #5 clk = ~clk;

   branch_compare_seq_if #(.WIDTH(W)) bus_if ();

   branch_compare_seq #(.WIDTH(W), .CHUNK(8)) dut (
      .i_clk       (clk),
      .i_rst_n     (rst_n),
      .cmp_if      (bus_if),
      .o_dbg_state (dbg_state)
   );

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- scoreboard ----------------
   int          total = 0;
   int          bad   = 0;
   logic [11:0] exp_q[$];   // {equal, less, taken, illegal, run_cycles[7:0]}

   typedef struct {
      logic [2:0]  f3;
      logic [31:0] a;
      logic [31:0] b;
      logic        eq;
      logic        lt;
      logic        tk;
      logic        il;
      int          cyc;
   } vec_t;

   vec_t vecs[10];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [11:0] pack(input logic eq, input logic lt, input logic tk,
                                        input logic il, input int cyc);
      return {eq, lt, tk, il, 8'(cyc)};
   endfunction

   // Whole-word reference: native signed/unsigned compare, latency from byte scan.
   function automatic logic [11:0] model(input logic [2:0] f3, input logic [31:0] a,
                                         input logic [31:0] b);
      logic eq, lt, tk, il;
      int   k;
      eq = (a == b);
      lt = f3[1] ? (a < b) : ($signed(a) < $signed(b));
      il = (f3[2:1] == 2'b01);
      case (f3)
         3'd0:       tk = eq;
         3'd1:       tk = !eq;
         3'd4, 3'd6: tk = lt;
         3'd5, 3'd7: tk = !lt;
         default:    tk = 1'b0;
      endcase
      k = 1;
      for (int i = 3; i > 0; i--) begin
         if (a[i*8 +: 8] == b[i*8 +: 8]) k++;
         else break;
      end
      return pack(eq, lt, tk, il, k);
   endfunction

   // ---------------- driver tasks ----------------
   task automatic drive_req(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
      int n;
      @(negedge clk);
      n = 0;
      while (bus_if.o_ready !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      bus_if.i_valid  = 1'b1;
      bus_if.i_rd1    = a;
      bus_if.i_rd2    = b;
      bus_if.i_funct3 = f3;
   endtask

   // Waits for o_valid (bounded), pops the expected result and compares.
   task automatic wait_result(input string name);
      int          cyc;
      bit          seen;
      logic [11:0] e;
      cyc  = 0;
      seen = 0;
      while (!seen && cyc < 20) begin
         @(posedge clk);
         cyc++;
         #1;
         if (bus_if.o_valid === 1'b1) seen = 1;
      end
      e = exp_q.pop_front();
      if (!seen) begin
         total++;
         bad++;
         $display("FAIL %s: no o_valid within 20 cycles, expected %h", name, e);
      end else begin
         check(name, {20'd0, bus_if.o_br_equal, bus_if.o_br_less, bus_if.o_taken,
                      bus_if.o_illegal, 8'(cyc)}, {20'd0, e});
      end
   endtask

   task automatic run_req(input string name, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] b, input logic [11:0] exp);
      exp_q.push_back(exp);
      drive_req(f3, a, b);
      @(posedge clk);
      #1;
      check({name, " accept"}, {30'd0, dbg_state}, {30'd0, ST_RUN});
      @(negedge clk);
      bus_if.i_valid = 1'b0;
      bus_if.i_rd1   = $urandom;
      bus_if.i_rd2   = $urandom;
      wait_result(name);
      @(posedge clk);
      #1;
      check({name, " back to idle"}, {31'd0, bus_if.o_ready}, 32'd1);
   endtask

   task automatic no_valid_window(input string name);
      bit seen;
      seen = 0;
      for (int i = 0; i < 8; i++) begin
         @(posedge clk);
         #1;
         if (bus_if.o_valid === 1'b1) seen = 1;
      end
      check(name, {31'd0, seen}, 32'd0);
   endtask

   // ---------------- test ----------------
   initial begin
      logic [31:0] a, b;
      logic [2:0]  f3;
      logic [11:0] e;
      int          k;

      vecs[0] = '{3'b000, 32'h0000_0005, 32'h0000_0005, 1, 0, 1, 0, 4};
      vecs[1] = '{3'b100, 32'hFFFF_FFFF, 32'h0000_0001, 0, 1, 1, 0, 1};
      vecs[2] = '{3'b110, 32'hFFFF_FFFF, 32'h0000_0001, 0, 0, 0, 0, 1};
      vecs[3] = '{3'b111, 32'h1234_5600, 32'h1234_5601, 0, 1, 0, 0, 4};
      vecs[4] = '{3'b010, 32'h0000_0000, 32'h0000_0000, 1, 0, 0, 1, 4};
      vecs[5] = '{3'b001, 32'h8000_0000, 32'h7FFF_FFFF, 0, 1, 1, 0, 1};
      vecs[6] = '{3'b101, 32'h0001_0000, 32'h0002_0000, 0, 1, 0, 0, 2};
      vecs[7] = '{3'b110, 32'h0000_FF00, 32'h0000_FE00, 0, 0, 0, 0, 3};
      vecs[8] = '{3'b011, 32'h0000_0001, 32'h0000_0002, 0, 1, 0, 1, 4};
      vecs[9] = '{3'b101, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 0, 1, 0, 0, 4};

      bus_if.i_valid  = 1'b0;
      bus_if.i_rd1    = '0;
      bus_if.i_rd2    = '0;
      bus_if.i_funct3 = '0;
      bus_if.i_flush  = 1'b0;
      bus_if.i_ready  = 1'b1;

      // Reset state while reset is held.
      repeat (3) @(posedge clk);
      #1;
      check("rst state", {30'd0, dbg_state}, {30'd0, ST_IDLE});
      check("rst o_ready", {31'd0, bus_if.o_ready}, 32'd1);
      check("rst o_valid", {31'd0, bus_if.o_valid}, 32'd0);
      check("rst flags", {28'd0, bus_if.o_br_equal, bus_if.o_br_less, bus_if.o_taken,
                          bus_if.o_illegal}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // Table-driven vectors.
      foreach (vecs[i]) begin
         run_req($sformatf("vec%0d", i), vecs[i].f3, vecs[i].a, vecs[i].b,
                 pack(vecs[i].eq, vecs[i].lt, vecs[i].tk, vecs[i].il, vecs[i].cyc));
      end

      // Result held in DONE while i_ready is low; i_valid pulses are ignored.
      bus_if.i_ready = 1'b0;
      exp_q.push_back(pack(1, 0, 1, 0, 4));
      drive_req(3'b000, 32'h0000_00AA, 32'h0000_00AA);
      @(posedge clk);
      @(negedge clk);
      bus_if.i_valid = 1'b0;
      wait_result("hold result");
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         bus_if.i_valid  = (i != 1);
         bus_if.i_rd1    = 32'h8000_0000;
         bus_if.i_rd2    = 32'h0000_0001;
         bus_if.i_funct3 = 3'b001;
         @(posedge clk);
         #1;
         check($sformatf("hold%0d", i), {26'd0, dbg_state, bus_if.o_valid, bus_if.o_ready,
               bus_if.o_br_equal, bus_if.o_taken}, {26'd0, ST_DONE, 4'b1011});
      end
      @(negedge clk);
      bus_if.i_ready = 1'b1;
      bus_if.i_valid = 1'b1;
      @(posedge clk);
      #1;
      check("release no accept", {30'd0, dbg_state}, {30'd0, ST_IDLE});
      check("release o_valid", {31'd0, bus_if.o_valid}, 32'd0);
      @(negedge clk);
      bus_if.i_valid = 1'b0;
      check("flags retained", {30'd0, bus_if.o_br_equal, bus_if.o_taken}, 32'd3);

      // Flush in IDLE cancels a same-cycle accept.
      @(negedge clk);
      bus_if.i_valid = 1'b1;
      bus_if.i_flush = 1'b1;
      @(posedge clk);
      #1;
      check("idle flush cancels", {30'd0, dbg_state}, {30'd0, ST_IDLE});
      @(negedge clk);
      bus_if.i_valid = 1'b0;
      bus_if.i_flush = 1'b0;

      // Flush during the second RUN cycle.
      drive_req(3'b000, 32'h0000_0007, 32'h0000_0007);
      @(posedge clk);
      @(negedge clk);
      bus_if.i_valid = 1'b0;
      @(posedge clk);
      @(negedge clk);
      bus_if.i_flush = 1'b1;
      @(posedge clk);
      #1;
      check("flush to idle", {29'd0, dbg_state, bus_if.o_valid}, {29'd0, ST_IDLE, 1'b0});
      @(negedge clk);
      bus_if.i_flush = 1'b0;
      no_valid_window("flush no valid");
      run_req("after flush", 3'b100, 32'h0000_0010, 32'h0000_0020,
              model(3'b100, 32'h0000_0010, 32'h0000_0020));

      // Asynchronous reset during RUN.
      drive_req(3'b001, 32'h1111_1111, 32'h1111_1111);
      @(posedge clk);
      @(negedge clk);
      bus_if.i_valid = 1'b0;
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("rst mid run", {27'd0, dbg_state, bus_if.o_ready, bus_if.o_valid, bus_if.o_br_less},
            {27'd0, ST_IDLE, 3'b100});
      @(negedge clk);
      rst_n = 1'b1;
      no_valid_window("reset no valid");
      run_req("after reset", 3'b111, 32'hA000_0000, 32'h0A00_0000,
              model(3'b111, 32'hA000_0000, 32'h0A00_0000));

      // Random operands with a controlled position of the first differing byte.
      for (int n = 0; n < 16; n++) begin
         a  = $urandom;
         b  = a;
         k  = $urandom_range(0, 4);
         if (k < 4) b[k*8 +: 8] = b[k*8 +: 8] ^ 8'($urandom_range(1, 255));
         f3 = 3'($urandom_range(0, 7));
         e  = model(f3, a, b);
         run_req($sformatf("rand%0d", n), f3, a, b, e);
      end

      check("queue empty", exp_q.size(), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
